// File: rtl/fifo_pkg.sv
// Shared FIFO definitions for the read-side prefetcher and the write-side controller.
package fifo_pkg;

  localparam int FIFO_DSIZE = 8;
  localparam int FIFO_ASIZE = 4;
  localparam int OBUF_DEPTH = 2;

  typedef logic [FIFO_ASIZE:0] ptr_t;

  // Occupancy seen between two binary pointers; modulo arithmetic handles wrap.
  function automatic ptr_t ptr_diff(input ptr_t wptr, input ptr_t rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/fifo_read_prefetch_skid_buffer2.sv
// Two-entry output buffer that absorbs the registered RAM read latency.
// Head word is always in r_head; r_tail only holds the second word.
module skid_buffer2
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [DSIZE-1:0] head_data
);

  localparam logic [1:0] FULL_CNT = 2'(OBUF_DEPTH);

  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_tail;
  logic [1:0]       r_count;

  // Storage and occupancy update; simultaneous push/pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= push_data;
          else                 r_tail <= push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == FULL_CNT) begin
            r_head <= r_tail;
            r_tail <= push_data;
          end else begin
            r_head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count     = r_count;
  assign head_data = r_head;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (r_count == FULL_CNT)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && (r_count == 2'd0)));

endmodule

// File: rtl/fifo_read_prefetch.sv
// Read-side FIFO controller: issues registered RAM reads ahead of demand and
// presents a first-word-fall-through valid/ready stream.
module fifo_read_prefetch
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE:0]   wptr,
  output logic [ASIZE:0]   rptr,
  output logic             ram_rclken,
  output logic [ASIZE-1:0] ram_raddr,
  input  logic [DSIZE-1:0] ram_rdata,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [DSIZE-1:0] o_data,
  output logic             o_empty
);

  localparam logic [ASIZE:0] PTR_ONE = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] DEPTH_P = (ASIZE+1)'(1 << ASIZE);
  localparam logic [2:0]     OBUF_P  = 3'(OBUF_DEPTH);

  logic [ASIZE:0] r_rptr;
  logic           r_inflight;
  logic [1:0]     w_count;
  logic [2:0]     w_occ;
  logic           w_avail;
  logic           w_pop;
  logic           w_issue;

  assign w_avail = (wptr != r_rptr);
  assign w_pop   = o_valid & o_ready;
  // Words that will occupy the buffer after this edge, including the one in flight.
  assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = w_avail & (w_occ < OBUF_P) & ~rst;

  // Read pointer advances on issue; the RAM captures the address at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  skid_buffer2 #(.DSIZE(DSIZE)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (ram_rdata),
    .pop       (w_pop),
    .count     (w_count),
    .head_data (o_data)
  );

  assign rptr       = r_rptr;
  assign ram_rclken = w_issue;
  assign ram_raddr  = r_rptr[ASIZE-1:0];
  assign o_valid    = (w_count != 2'd0);
  assign o_empty    = (w_count == 2'd0) & ~r_inflight & ~w_avail;

  a_wptr_legal: assert property (@(posedge clk) disable iff (rst)
    ((wptr - r_rptr) <= DEPTH_P));

endmodule
